// File: rtl/pong_rally_ctrl.sv
// Pong rally sequencer: ball, direction, rally speed, scores; define PONG_EARLY_FOUL_EN to make in-flight hits a foul.
// All outputs registered with one-cycle latency; no backpressure, every input is a single-cycle pulse.
module pong_rally_ctrl #(
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned SERVE_TICKS = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Start,
  input  logic       P1Hit,
  input  logic       P2Hit,
  input  logic       Tick,
  output logic [7:0] LightOut,
  output logic       TmrEn,
  output logic       TmrRst,
  output logic [1:0] Speed,
  output logic [3:0] Score1,
  output logic [3:0] Score2,
  output logic [1:0] Winner
);

  typedef enum logic [2:0] {
    S_IDLE, S_SERVE, S_MOVE_L, S_MOVE_R, S_POINT, S_GAMEOVER
  } state_t;

  localparam logic [7:0] P1_EDGE    = 8'h80;
  localparam logic [7:0] P2_EDGE    = 8'h01;
  localparam logic [7:0] P1_FLAG    = 8'hF0;
  localparam logic [7:0] P2_FLAG    = 8'h0F;
  localparam logic [3:0] WIN_Q      = 4'(WIN_SCORE);
  localparam logic [3:0] SERVE_LAST = 4'(SERVE_TICKS - 1);

  state_t      state_q, state_d;
  logic [7:0]  light_q, light_d;
  logic        tmr_en_q, tmr_en_d;
  logic        tmr_rst_q, tmr_rst_d;
  logic [3:0]  rally_q, rally_d;
  logic [3:0]  score1_q, score1_d;
  logic [3:0]  score2_q, score2_d;
  logic [1:0]  winner_q, winner_d;
  logic        server_q, server_d;   // 0 = P1 serves next, 1 = P2
  logic [3:0]  serve_cnt_q, serve_cnt_d;

  logic go_serve, go_point, point_p1;

  always_comb begin
    state_d     = state_q;
    light_d     = light_q;
    tmr_rst_d   = 1'b0;
    rally_d     = rally_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    winner_d    = winner_q;
    server_d    = server_q;
    serve_cnt_d = serve_cnt_q;
    go_serve    = 1'b0;
    go_point    = 1'b0;
    point_p1    = 1'b0;

    case (state_q)
      S_IDLE, S_GAMEOVER: begin
        if (Start) begin
          go_serve = 1'b1;
          score1_d = 4'd0;
          score2_d = 4'd0;
          winner_d = 2'b00;
          server_d = 1'b0;
        end
      end
      S_SERVE: begin
        if (Tick) begin
          if (serve_cnt_q == SERVE_LAST) begin
            state_d = server_q ? S_MOVE_L : S_MOVE_R;
            light_d = server_q ? (light_q << 1) : (light_q >> 1);
          end else begin
            serve_cnt_d = serve_cnt_q + 4'd1;
          end
        end
      end
      S_MOVE_R: begin
        if (P2Hit && light_q == P2_EDGE) begin
          state_d   = S_MOVE_L;
          rally_d   = (rally_q == 4'd15) ? rally_q : rally_q + 4'd1;
          tmr_rst_d = 1'b1;
        end else if (Tick && light_q == P2_EDGE) begin
          go_point = 1'b1;
          point_p1 = 1'b1;
`ifdef PONG_EARLY_FOUL_EN
        end else if (P2Hit) begin
          go_point = 1'b1;
          point_p1 = 1'b1;
`endif
        end else if (Tick) begin
          light_d = light_q >> 1;
        end
      end
      S_MOVE_L: begin
        if (P1Hit && light_q == P1_EDGE) begin
          state_d   = S_MOVE_R;
          rally_d   = (rally_q == 4'd15) ? rally_q : rally_q + 4'd1;
          tmr_rst_d = 1'b1;
        end else if (Tick && light_q == P1_EDGE) begin
          go_point = 1'b1;
          point_p1 = 1'b0;
`ifdef PONG_EARLY_FOUL_EN
        end else if (P1Hit) begin
          go_point = 1'b1;
          point_p1 = 1'b0;
`endif
        end else if (Tick) begin
          light_d = light_q << 1;
        end
      end
      S_POINT: begin
        if (Tick) begin
          if (score1_q == WIN_Q) begin
            state_d  = S_GAMEOVER;
            light_d  = P1_FLAG;
            winner_d = 2'b01;
          end else if (score2_q == WIN_Q) begin
            state_d  = S_GAMEOVER;
            light_d  = P2_FLAG;
            winner_d = 2'b10;
          end else begin
            go_serve = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // server_d already names the player who serves; on a point it becomes the loser
    if (go_serve) begin
      state_d     = S_SERVE;
      light_d     = server_d ? P2_EDGE : P1_EDGE;
      tmr_rst_d   = 1'b1;
      rally_d     = 4'd0;
      serve_cnt_d = 4'd0;
    end

    if (go_point) begin
      state_d = S_POINT;
      if (point_p1) begin
        score1_d = score1_q + 4'd1;
        light_d  = P1_FLAG;
        server_d = 1'b1;
      end else begin
        score2_d = score2_q + 4'd1;
        light_d  = P2_FLAG;
        server_d = 1'b0;
      end
    end

    tmr_en_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      light_q     <= 8'h00;
      tmr_en_q    <= 1'b0;
      tmr_rst_q   <= 1'b0;
      rally_q     <= 4'd0;
      score1_q    <= 4'd0;
      score2_q    <= 4'd0;
      winner_q    <= 2'b00;
      server_q    <= 1'b0;
      serve_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      light_q     <= light_d;
      tmr_en_q    <= tmr_en_d;
      tmr_rst_q   <= tmr_rst_d;
      rally_q     <= rally_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      winner_q    <= winner_d;
      server_q    <= server_d;
      serve_cnt_q <= serve_cnt_d;
    end
  end

  assign LightOut = light_q;
  assign TmrEn    = tmr_en_q;
  assign TmrRst   = tmr_rst_q;
  assign Speed    = rally_q[3:2];
  assign Score1   = score1_q;
  assign Score2   = score2_q;
  assign Winner   = winner_q;

endmodule

// File: tb/tb_pong_rally_ctrl.sv
// Randomized bench for pong_rally_ctrl: a behavioural game model queues the expected outputs,
// a negedge monitor pops and compares them against the DUT every cycle.
module tb_pong_rally_ctrl;

  localparam int WIN = 3;
  localparam int SRV = 3;
`ifdef PONG_EARLY_FOUL_EN
  localparam bit FOUL = 1'b1;
`else
  localparam bit FOUL = 1'b0;
`endif

  localparam int PH_IDLE = 0, PH_SERVE = 1, PH_FLIGHT = 2, PH_POINT = 3, PH_OVER = 4;

  logic       Clk = 1'b0;
  logic       Rst, Start, P1Hit, P2Hit, Tick;
  logic [7:0] LightOut;
  logic       TmrEn, TmrRst;
  logic [1:0] Speed, Winner;
  logic [3:0] Score1, Score2;

  always #5 Clk = ~Clk;

  pong_rally_ctrl #(.WIN_SCORE(WIN), .SERVE_TICKS(SRV)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .P1Hit(P1Hit), .P2Hit(P2Hit), .Tick(Tick),
    .LightOut(LightOut), .TmrEn(TmrEn), .TmrRst(TmrRst), .Speed(Speed),
    .Score1(Score1), .Score2(Score2), .Winner(Winner)
  );

  typedef struct packed {
    logic [7:0] light;
    logic       en;
    logic       trst;
    logic [1:0] spd;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [1:0] win;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Game model: ball as an LED index (7 = P1 end, 0 = P2 end) plus a direction flag
  int ph, pos, server, s1, s2, rally, cnt, winner, scorer;
  bit toward_p2, trst;

  task automatic check_val(input logic [31:0] got_v, input logic [31:0] exp_v, input string what);
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, want %0h", what, $time, got_v, exp_v);
    end
  endtask

  task automatic serve_begin(input int srv);
    server = srv;
    ph     = PH_SERVE;
    pos    = (srv == 1) ? 7 : 0;
    cnt    = 0;
    rally  = 0;
    trst   = 1'b1;
  endtask

  task automatic new_game();
    s1 = 0; s2 = 0; winner = 0;
    serve_begin(1);
  endtask

  task automatic award(input int p);
    scorer = p;
    if (p == 1) s1++; else s2++;
    ph = PH_POINT;
  endtask

  task automatic model_step(input bit rst, input bit start, input bit p1, input bit p2, input bit tick);
    bit rh, at_edge;
    trst = 1'b0;
    if (rst) begin
      ph = PH_IDLE; pos = 0; server = 1; s1 = 0; s2 = 0; rally = 0; cnt = 0;
      winner = 0; scorer = 0; toward_p2 = 1'b0;
    end else begin
      case (ph)
        PH_IDLE, PH_OVER: if (start) new_game();
        PH_SERVE: if (tick) begin
          cnt++;
          if (cnt == SRV) begin
            ph = PH_FLIGHT;
            toward_p2 = (server == 1);
            pos = toward_p2 ? 6 : 1;
          end
        end
        PH_FLIGHT: begin
          rh      = toward_p2 ? p2 : p1;
          at_edge = (pos == (toward_p2 ? 0 : 7));
          if (rh && at_edge) begin
            toward_p2 = !toward_p2;
            rally = (rally < 15) ? rally + 1 : 15;
            trst = 1'b1;
          end else if (tick && at_edge) begin
            award(toward_p2 ? 1 : 2);
          end else if (FOUL && rh) begin
            award(toward_p2 ? 1 : 2);
          end else if (tick) begin
            pos = toward_p2 ? pos - 1 : pos + 1;
          end
        end
        PH_POINT: if (tick) begin
          if (((scorer == 1) ? s1 : s2) == WIN) begin
            ph = PH_OVER;
            winner = scorer;
          end else begin
            serve_begin(scorer == 1 ? 2 : 1);
          end
        end
        default: ph = PH_IDLE;
      endcase
    end
  endtask

  function automatic obs_t model_out();
    obs_t o;
    o = '0;
    if (ph == PH_SERVE || ph == PH_FLIGHT) o.light[pos] = 1'b1;
    else if (ph == PH_POINT || ph == PH_OVER) o.light = (scorer == 1) ? 8'hF0 : 8'h0F;
    o.en   = (ph != PH_IDLE);
    o.trst = trst;
    o.spd  = 2'(rally / 4);
    o.s1   = 4'(s1);
    o.s2   = 4'(s2);
    o.win  = (winner == 1) ? 2'b01 : (winner == 2) ? 2'b10 : 2'b00;
    return o;
  endfunction

  obs_t got, e;
  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {LightOut, TmrEn, TmrRst, Speed, Score1, Score2, Winner};
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL outputs @%0t: got light=%h en=%b trst=%b spd=%0d s1=%0d s2=%0d win=%b, want light=%h en=%b trst=%b spd=%0d s1=%0d s2=%0d win=%b",
                 $time, got.light, got.en, got.trst, got.spd, got.s1, got.s2, got.win,
                 e.light, e.en, e.trst, e.spd, e.s1, e.s2, e.win);
      end
    end
  end

  initial begin
    int  tick_pct, hit_pct, waited;
    bit  r, st, h1, h2, tk, at_edge, want_mid_rst;

    Rst = 1'b1; Start = 1'b0; P1Hit = 1'b0; P2Hit = 1'b0; Tick = 1'b0;
    model_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(model_out());

    for (int seg = 0; seg < 6; seg++) begin
      tick_pct     = (seg % 3 == 0) ? 100 : (seg % 3 == 1) ? 40 : 15;
      hit_pct      = (seg < 3) ? 92 : 65;
      want_mid_rst = (seg == 2 || seg == 4);
      for (int i = 0; i < 1200; i++) begin
        @(posedge Clk);
        #1;
        if (seg == 0 && i == 0) begin
          check_val(32'(LightOut), 32'h00, "reset LightOut");
          check_val(32'(TmrEn),    32'h0,  "reset TmrEn");
          check_val(32'(TmrRst),   32'h0,  "reset TmrRst");
          check_val(32'(Speed),    32'h0,  "reset Speed");
          check_val(32'(Score1),   32'h0,  "reset Score1");
          check_val(32'(Score2),   32'h0,  "reset Score2");
          check_val(32'(Winner),   32'h0,  "reset Winner");
        end
        at_edge = (ph == PH_FLIGHT) && (pos == (toward_p2 ? 0 : 7));
        tk = ($urandom_range(0, 99) < tick_pct);
        h1 = ($urandom_range(0, 99) < 3);
        h2 = ($urandom_range(0, 99) < 3);
        if (at_edge && $urandom_range(0, 99) < hit_pct) begin
          if (toward_p2) h2 = 1'b1; else h1 = 1'b1;
        end
        st = (ph == PH_IDLE || ph == PH_OVER) ? ($urandom_range(0, 99) < 6)
                                              : ($urandom_range(0, 99) < 1);
        r  = ($urandom_range(0, 1999) == 0);
        // one reset per chosen segment while the ball travels toward P1
        if (want_mid_rst && i > 300 && ph == PH_FLIGHT && !toward_p2) begin
          r = 1'b1;
          want_mid_rst = 1'b0;
        end
        if (i < 2 && seg == 0) r = 1'b1;
        Rst = r; Start = st; P1Hit = h1; P2Hit = h2; Tick = tk;
        model_step(r, st, h1, h2, tk);
        exp_q.push_back(model_out());
      end
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 8) begin
      @(negedge Clk);
      #1;
      waited++;
    end
    check_val(32'(exp_q.size()), 32'd0, "expected queue drained before wait expired");
    check_val(32'(n_cmp), 32'(1 + 6 * 1200), "number of compared cycles");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
